vram_scanout: RTL and testbench

- Read side of the double-buffered VRAM that the sprite processing unit writes.
- Generates VGA raster timing and fetches palette-index pixels from the front bank, replicating each one SCALE×SCALE.
- Drives registered pixel, data-enable and sync outputs.
- Performs the bank-swap handshake with the writer at vertical-blank start, so a frame never tears.

---
 rtl/vram_scanout.sv | 127 ++++++++++++
 tb/tb_vram_scanout.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// VGA scan-out for the sprite unit's double-buffered VRAM: raster timing, SCALE x SCALE
// pixel replication from the front bank, and a tear-free bank swap at vblank start.
module vram_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15,
  parameter int PIX_W      = 4,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rd_en,
  output logic [ADDR_W:0]   rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_bank,
  output logic              frame_start,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [PIX_W-1:0]  pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE >> SCALE_LOG2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic              active, hs_win, vs_win, vblank_start;
  logic [ADDR_W-1:0] fb_addr;
  logic              s1_hs, s1_vs;
  logic              s2_act, s2_hs, s2_vs;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // NOTE: every always_comb output is assigned on all paths, so no latches are inferred.
  always_comb begin
    active       = (h < H_ACT) && (v < V_ACT);
    hs_win       = (h >= HS_BEG) && (h < HS_END);
    vs_win       = (v >= VS_BEG) && (v < VS_END);
    vblank_start = (h == '0) && (v == V_ACT);
    fb_addr      = ADDR_W'(v >> SCALE_LOG2) * ADDR_W'(FB_W) + ADDR_W'(h >> SCALE_LOG2);
  end

  // Stage 1: issue the VRAM read; sync windows ride alongside so they stay aligned with pixel data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      frame_start <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
    end else begin
      rd_en       <= active;
      rd_addr     <= active ? {front_bank, fb_addr} : '0;
      frame_start <= (h == '0) && (v == '0);
      s1_hs       <= hs_win;
      s1_vs       <= vs_win;
    end
  end

  // Stage 2 waits out the RAM latency; stage 3 registers the visible outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_act <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      de     <= 1'b0;
      pixel  <= '0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
    end else begin
      s2_act <= rd_en;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      de     <= s2_act;
      pixel  <= s2_act ? rd_data : '0;
      hsync  <= s2_hs ? SYNC_POL : ~SYNC_POL;
      vsync  <= s2_vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  // The swap is only sampled at vblank start, when no active fetch is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_bank <= 1'b0;
      swap_ack   <= 1'b0;
    end else if (vblank_start && swap_req) begin
      front_bank <= ~front_bank;
      swap_ack   <= 1'b1;
    end else begin
      swap_ack   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout on a reduced raster; a cycle model feeds a scoreboard of
// expected outputs that is popped as the three-stage pipeline delivers them.
module tb_vram_scanout;

  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3;
  localparam int SL = 2, AW = 15, PW = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int SC = 1 << SL;
  localparam int FBW = HA / SC;

  typedef struct packed {
    logic          de;
    logic          hsync;
    logic          vsync;
    logic [PW-1:0] pixel;
  } out_t;

  typedef struct packed {
    logic          rd_en;
    logic [AW:0]   rd_addr;
    logic          frame_start;
    logic          swap_ack;
    logic          front_bank;
    out_t          o;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          swap_req = 1'b0;
  logic [PW-1:0] rd_data = '0;
  logic          rd_en, swap_ack, front_bank, frame_start, hsync, vsync, de;
  logic [AW:0]   rd_addr;
  logic [PW-1:0] pixel;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mh = 0, mv = 0;
  logic mbank = 1'b0;
  out_t sb[$];
  int   cyc = 0, fs_cyc = 0;
  bit   fs_valid = 0;
  int   de_run = 0, hs_run = 0, vs_run = 0;
  logic vs_prev = 1'b1;

  localparam out_t OUT_RST = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1, pixel: '0};

  vram_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_LOG2(SL), .ADDR_W(AW), .PIX_W(PW), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_bank(front_bank),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel)
  );

  always #5 clk = ~clk;

  // VRAM stand-in: returns the low address bits one cycle after sampling.
  always @(posedge clk) rd_data <= rd_addr[PW-1:0];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t s;
    s.rd_en       = rd_en;
    s.rd_addr     = rd_addr;
    s.frame_start = frame_start;
    s.swap_ack    = swap_ack;
    s.front_bank  = front_bank;
    s.o.de        = de;
    s.o.hsync     = hsync;
    s.o.vsync     = vsync;
    s.o.pixel     = pixel;
    return s;
  endfunction

  function automatic obs_t rst_obs();
    obs_t s;
    s   = '0;
    s.o = OUT_RST;
    return s;
  endfunction

  // One clock: model the stage-1 result of the counter state held before the edge.
  task automatic step();
    logic req_seen;
    logic act;
    int   ph, pv;
    obs_t exp;
    out_t fin;
    int   th[5] = '{0, 3, 4, 0, HA - 1};
    int   tv[5] = '{0, 0, 0, SC, VA - 1};
    int   ta[5] = '{0, 0, 1, FBW, (VA / SC) * FBW - 1};
    req_seen = swap_req;
    @(posedge clk);
    #1;
    cyc++;
    ph  = mh;
    pv  = mv;
    act = (ph < HA) && (pv < VA);
    exp = '0;
    exp.rd_en       = act;
    exp.rd_addr     = act ? {mbank, AW'((pv / SC) * FBW + ph / SC)} : '0;
    exp.frame_start = (ph == 0) && (pv == 0);
    exp.swap_ack    = (ph == 0) && (pv == VA) && req_seen;
    if (exp.swap_ack) mbank = ~mbank;
    exp.front_bank  = mbank;
    fin.de    = act;
    fin.hsync = !((ph >= HA + HF) && (ph < HA + HF + HS));
    fin.vsync = !((pv >= VA + VF) && (pv < VA + VF + VS));
    fin.pixel = act ? exp.rd_addr[PW-1:0] : '0;
    sb.push_back(fin);
    exp.o = sb.pop_front();
    mh = ph + 1;
    if (mh == HT) begin
      mh = 0;
      mv = (pv == VT - 1) ? 0 : pv + 1;
    end
    check("cycle", 64'(sample()), 64'(exp));

    for (int i = 0; i < 5; i++)
      if (ph == th[i] && pv == tv[i]) check("addr_map", 64'(rd_addr[AW-1:0]), 64'(ta[i]));
    if (!de) check("pixel_blank", 64'(pixel), 64'(0));

    if (de) de_run++;
    else if (de_run != 0) begin check("de_run", 64'(de_run), 64'(HA)); de_run = 0; end
    if (!hsync) hs_run++;
    else if (hs_run != 0) begin check("hsync_run", 64'(hs_run), 64'(HS)); hs_run = 0; end
    if (!vsync) vs_run++;
    else if (vs_run != 0) begin check("vsync_run", 64'(vs_run), 64'(VS * HT)); vs_run = 0; end
    if (!vsync && vs_prev && fs_valid)
      check("vsync_start", 64'(cyc - fs_cyc), 64'((VA + VF) * HT + 2));
    vs_prev = vsync;
    if (frame_start) begin
      if (fs_valid) check("frame_period", 64'(cyc - fs_cyc), 64'(HT * VT));
      fs_cyc   = cyc;
      fs_valid = 1;
    end
  endtask

  task automatic run_to(input int th, input int tv);
    int n = 0;
    while (!(mh == th && mv == tv) && n < HT * VT + 2) begin
      step();
      n++;
    end
  endtask

  task automatic reset_and_release();
    rst = 1'b1;
    #1;
    check("reset_async", 64'(sample()), 64'(rst_obs()));
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 64'(sample()), 64'(rst_obs()));
    @(negedge clk);
    rst = 1'b0;
    mh = 0; mv = 0; mbank = 1'b0;
    sb.delete();
    sb.push_back(OUT_RST);
    sb.push_back(OUT_RST);
    de_run = 0; hs_run = 0; vs_run = 0; vs_prev = 1'b1; fs_valid = 0;
  endtask

  task automatic first_cycles();
    step();
    check("first_frame_start", 64'(frame_start), 64'(1));
    check("first_rd_addr", 64'(rd_addr), 64'(0));
    check("first_rd_en", 64'(rd_en), 64'(1));
    check("first_de_c1", 64'(de), 64'(0));
    step();
    check("first_de_c2", 64'(de), 64'(0));
    step();
    check("first_de_c3", 64'(de), 64'(1));
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    reset_and_release();
    first_cycles();

    // Request held from line 5 is honoured at vblank start.
    run_to(0, 5);
    swap_req = 1'b1;
    run_to(0, VA);
    check("bank_before_swap", 64'(front_bank), 64'(0));
    step();
    check("swap_ack_pulse", 64'(swap_ack), 64'(1));
    check("bank_after_swap", 64'(front_bank), 64'(1));
    swap_req = 1'b0;
    step();
    check("swap_ack_single", 64'(swap_ack), 64'(0));
    run_to(0, 0);
    step();
    check("new_frame_msb", 64'(rd_addr[AW]), 64'(1));

    // A request that is gone by vblank start is not remembered.
    run_to(0, 8);
    swap_req = 1'b1;
    run_to(0, 9);
    swap_req = 1'b0;
    run_to(0, VA);
    step();
    check("pulse_no_ack", 64'(swap_ack), 64'(0));
    check("pulse_no_swap", 64'(front_bank), 64'(1));

    // Asynchronous reset in the middle of an active line.
    run_to(20, 10);
    reset_and_release();
    first_cycles();

    // Persistent request: one swap per frame.
    swap_req = 1'b1;
    for (int f = 0; f < 3; f++) begin
      run_to(0, VA);
      step();
      check("persist_ack", 64'(swap_ack), 64'(1));
      check("persist_bank", 64'(front_bank), 64'((f % 2 == 0) ? 1 : 0));
      step();
      check("persist_ack_low", 64'(swap_ack), 64'(0));
    end
    swap_req = 1'b0;
    run_to(0, 0);
    run_to(0, VA);
    step();
    check("final_no_ack", 64'(swap_ack), 64'(0));
    check("final_bank", 64'(front_bank), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
